// File: rtl/spi_master.sv
// Mode-0 SPI master: serialises tx_data MSB first on MOSI/sclk with an
// active-high CS, and captures MISO into rx_data.
// Ports: clk, rst (sync, active-low), start/tx_data in, busy/done/rx_data
// out, SPI pins sclk/MOSI/CS out and MISO in. All outputs are registered.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              MOSI,
  output logic              CS,
  input  logic              MISO
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxd_q, rxd_d;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_end = (cnt_q == CNT_LAST);
    tx_sh   = tx_q << 1;
    rx_sh   = rx_q << 1;
    rx_sh[0] = MISO;
    unique case (state_q)
      // FINISH accepts start directly, giving a one-cycle CS gap
      IDLE, FINISH: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_d    = 1'b0;
        mosi_d  = 1'b0;
        if (start) begin
          state_d = SETUP;
          tx_d    = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = rx_sh;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = LOW;
          // last bit keeps MOSI stable through the hold window
          if (bit_q != BIT_LAST) begin
            tx_d   = tx_sh;
            mosi_d = tx_sh[DATA_W-1];
          end
        end
      end
      LOW: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BW'(1);
            sclk_d  = 1'b1;
            rx_d    = rx_sh;
            state_d = HIGH;
          end else begin
            state_d = FINISH;
            cs_d    = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rxd_d   = rx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rxd_q;
  assign sclk    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS      = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance (8 bit, div 4) and a
// div-1 instance, with loopback or tied MISO.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel, lb, miso_v;
  logic [7:0] tx_data;
  logic       start0, start1, miso0, miso1;
  logic       busy0, done0, sclk0, mosi0, cs0;
  logic       busy1, done1, sclk1, mosi1, cs1;
  logic [7:0] rx0, rx1;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign miso0  = lb ? mosi0 : miso_v;
  assign miso1  = lb ? mosi1 : miso_v;

  spi_master u0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx_data),
    .busy(busy0), .done(done0), .rx_data(rx0), .sclk(sclk0),
    .MOSI(mosi0), .CS(cs0), .MISO(miso0)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data),
    .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1),
    .MOSI(mosi1), .CS(cs1), .MISO(miso1)
  );

  logic       busy_w, done_w, sclk_w, mosi_w, cs_w;
  logic [7:0] rx_w;
  assign busy_w = sel ? busy1 : busy0;
  assign done_w = sel ? done1 : done0;
  assign sclk_w = sel ? sclk1 : sclk0;
  assign mosi_w = sel ? mosi1 : mosi0;
  assign cs_w   = sel ? cs1 : cs0;
  assign rx_w   = sel ? rx1 : rx0;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(
    input  logic [7:0] tx,
    input  int         poke,
    output int         cs_first,
    output int         cs_last,
    output int         cs_n,
    output int         rises,
    output logic [7:0] bits,
    output int         done_at,
    output int         ndone,
    output bit         busy_bad,
    output logic [7:0] rx,
    output logic       busy_end
  );
    logic prev;
    cs_first = -1; cs_last = -1; cs_n = 0; rises = 0;
    bits = 8'h00; done_at = -1; ndone = 0; busy_bad = 0;
    rx = 8'h00; prev = 1'b0; busy_end = 1'b1;
    @(negedge clk);
    start = 1'b1;
    tx_data = tx;
    tick();
    start = 1'b0;
    tx_data = 8'h00;
    for (int n = 1; n <= 200; n++) begin
      if (cs_w) begin
        if (cs_first < 0) cs_first = n;
        cs_last = n;
        cs_n++;
      end
      if (sclk_w && !prev) begin
        bits = {bits[6:0], mosi_w};
        rises++;
      end
      prev = sclk_w;
      if (done_w) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n;
          rx = rx_w;
        end
      end
      if (done_at < 0 && !busy_w) busy_bad = 1;
      start = (n == poke);
      tx_data = (n == poke) ? 8'hFF : 8'h00;
      if (done_at >= 0 && n >= done_at + 5) begin
        busy_end = busy_w;
        break;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; sel = 1'b0; lb = 1'b1;
    miso_v = 1'b0; tx_data = 8'hA5;
    repeat (3) tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done0); end
    checks++; if (cs0 !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", mosi0); end
    checks++; if (rx0 !== 8'h00) begin errors++; $display("FAIL rst_rx got %h want 00", rx0); end
    checks++; if ({busy1, cs1, sclk1, rx1} !== 11'd0) begin errors++; $display("FAIL rst_div1 got %b want 0", {busy1, cs1, sclk1, rx1}); end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_loopback();
    int cf, cl, cn, rs, da, nd; bit bb; logic [7:0] bt, rx; logic be;
    sel = 1'b0; lb = 1'b1;
    run_xfer(8'hA5, -1, cf, cl, cn, rs, bt, da, nd, bb, rx, be);
    checks++; if (cf !== 1) begin errors++; $display("FAIL lb_cs_first got %0d want 1", cf); end
    checks++; if (cl !== 68) begin errors++; $display("FAIL lb_cs_last got %0d want 68", cl); end
    checks++; if (cn !== 68) begin errors++; $display("FAIL lb_cs_len got %0d want 68", cn); end
    checks++; if (rs !== 8) begin errors++; $display("FAIL lb_rises got %0d want 8", rs); end
    checks++; if (bt !== 8'hA5) begin errors++; $display("FAIL lb_mosi got %h want a5", bt); end
    checks++; if (da !== 69) begin errors++; $display("FAIL lb_done_at got %0d want 69", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL lb_ndone got %0d want 1", nd); end
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL lb_rx got %h want a5", rx); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL lb_busy got %b want 0", bb); end
    checks++; if (rx0 !== 8'hA5) begin errors++; $display("FAIL lb_rx_hold got %h want a5", rx0); end
  endtask

  task automatic test_div1();
    int cf, cl, cn, rs, da, nd; bit bb; logic [7:0] bt, rx; logic be;
    sel = 1'b1; lb = 1'b0; miso_v = 1'b1;
    run_xfer(8'h3C, -1, cf, cl, cn, rs, bt, da, nd, bb, rx, be);
    checks++; if (cn !== 17 || cf !== 1) begin errors++; $display("FAIL d1_cs got %0d/%0d want 17/1", cn, cf); end
    checks++; if (da !== 18) begin errors++; $display("FAIL d1_done_at got %0d want 18", da); end
    checks++; if (rs !== 8) begin errors++; $display("FAIL d1_rises got %0d want 8", rs); end
    checks++; if (bt !== 8'h3C) begin errors++; $display("FAIL d1_mosi got %h want 3c", bt); end
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL d1_rx1 got %h want ff", rx); end
    miso_v = 1'b0;
    run_xfer(8'h3C, -1, cf, cl, cn, rs, bt, da, nd, bb, rx, be);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL d1_rx0 got %h want 00", rx); end
    checks++; if (da !== 18) begin errors++; $display("FAIL d1_done_at2 got %0d want 18", da); end
    sel = 1'b0;
  endtask

  task automatic test_start_busy();
    int cf, cl, cn, rs, da, nd; bit bb; logic [7:0] bt, rx; logic be;
    sel = 1'b0; lb = 1'b1;
    run_xfer(8'h12, 10, cf, cl, cn, rs, bt, da, nd, bb, rx, be);
    checks++; if (bt !== 8'h12) begin errors++; $display("FAIL sb_mosi got %h want 12", bt); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL sb_ndone got %0d want 1", nd); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL sb_busy_drop got %b want 0", bb); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL sb_busy_end got %b want 0", be); end
    checks++; if (rx !== 8'h12) begin errors++; $display("FAIL sb_rx got %h want 12", rx); end
    checks++; if (da !== 69) begin errors++; $display("FAIL sb_done_at got %0d want 69", da); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, lows, rises;
    logic [7:0] r1, r2;
    logic prev;
    d1 = -1; d2 = -1; lows = 0; rises = 0; prev = 1'b0;
    r1 = 8'h00; r2 = 8'h00;
    sel = 1'b0; lb = 1'b1;
    @(negedge clk);
    start = 1'b1;
    tx_data = 8'h81;
    tick();
    tx_data = 8'h7E;
    for (int n = 1; n <= 300; n++) begin
      if (!cs_w) lows++;
      if (sclk_w && !prev) rises++;
      prev = sclk_w;
      if (done_w) begin
        if (d1 < 0) begin d1 = n; r1 = rx_w; end
        else begin d2 = n; r2 = rx_w; end
      end
      if (d1 >= 0 && n == d1 + 1) start = 1'b0;
      if (d2 >= 0) break;
      tick();
    end
    start = 1'b0;
    checks++; if (d1 !== 69) begin errors++; $display("FAIL b2b_d1 got %0d want 69", d1); end
    checks++; if (d2 !== 138) begin errors++; $display("FAIL b2b_d2 got %0d want 138", d2); end
    checks++; if (lows !== 2) begin errors++; $display("FAIL b2b_cs_low got %0d want 2", lows); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL b2b_rises got %0d want 16", rises); end
    checks++; if (r1 !== 8'h81) begin errors++; $display("FAIL b2b_rx1 got %h want 81", r1); end
    checks++; if (r2 !== 8'h7E) begin errors++; $display("FAIL b2b_rx2 got %h want 7e", r2); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int cf, cl, cn, rs, da, nd, spur; bit bb; logic [7:0] bt, rx; logic be;
    sel = 1'b0; lb = 1'b1; spur = 0;
    @(negedge clk);
    start = 1'b1;
    tx_data = 8'hA5;
    tick();
    start = 1'b0;
    for (int n = 1; n < 30; n++) tick();
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL rm_pre_cs got %b want 1", cs0); end
    rst = 1'b0;
    tick();
    if (done0) spur++;
    checks++; if ({cs0, sclk0, busy0, mosi0} !== 4'b0) begin errors++; $display("FAIL rm_pins got %b want 0000", {cs0, sclk0, busy0, mosi0}); end
    checks++; if (rx0 !== 8'h00) begin errors++; $display("FAIL rm_rx got %h want 00", rx0); end
    rst = 1'b1;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (done0 || cs0) spur++;
    end
    checks++; if (spur !== 0) begin errors++; $display("FAIL rm_spurious got %0d want 0", spur); end
    run_xfer(8'h5A, -1, cf, cl, cn, rs, bt, da, nd, bb, rx, be);
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL rm_rx_after got %h want 5a", rx); end
    checks++; if (da !== 69) begin errors++; $display("FAIL rm_done_at got %0d want 69", da); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_div1();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
